// File: rtl/riscv_pkg.sv
// Shared pipeline control types: the decoded control bundle carried from E to W.
// The all-zero bundle doubles as the bubble and matches the decoder's opcode-0 encoding.
package riscv_pkg;

  localparam int ALU_CTRL_BITS = 3;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic                     MemWrite;
    logic                     Jump;
    logic                     Branch;
    logic                     ALUSrcA;
    logic                     ALUSrcB;
    logic [ALU_CTRL_BITS-1:0] ALUControl;
    logic                     valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side control inputs, hazard inputs and E/M/W control outputs of ctrl_pipe.
// master = decoder/hazard/datapath side, slave = ctrl_pipe.
interface ctrl_pipe_if #(
  parameter int CNT_W     = 32,
  parameter int ALUCTRL_W = 3
);
  logic                 ValidD;
  logic                 IllegalD;
  logic                 RegWriteD;
  logic [1:0]           ResultSrcD;
  logic                 MemWriteD;
  logic                 JumpD;
  logic                 BranchD;
  logic                 ALUSrcAD;
  logic                 ALUSrcBD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic                 FlushE;
  logic                 ZeroE;
  logic                 illegal_clr;

  logic                 ALUSrcAE;
  logic                 ALUSrcBE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 ResultSrcE0;
  logic                 RegWriteE;
  logic                 PCSrcE;
  logic                 RegWriteM;
  logic                 MemWriteM;
  logic [1:0]           ResultSrcM;
  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;
  logic [CNT_W-1:0]     retired;
  logic                 illegal_seen;

  modport master (
    output ValidD, IllegalD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
           ALUSrcAD, ALUSrcBD, ALUControlD, FlushE, ZeroE, illegal_clr,
    input  ALUSrcAE, ALUSrcBE, ALUControlE, ResultSrcE0, RegWriteE, PCSrcE,
           RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, retired, illegal_seen
  );

  modport slave (
    input  ValidD, IllegalD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
           ALUSrcAD, ALUSrcBD, ALUControlD, FlushE, ZeroE, illegal_clr,
    output ALUSrcAE, ALUSrcBE, ALUControlE, ResultSrcE0, RegWriteE, PCSrcE,
           RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW, retired, illegal_seen
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One control pipeline register; latency 1 cycle, no backpressure.
// Synchronous flush loads a bubble; asynchronous reset clears to a bubble.
module ctrl_stage_reg
  import riscv_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  ctrl_t d,
  output ctrl_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CTRL_BUBBLE;
    end else if (flush) begin
      q <= CTRL_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded controls D->E->M->W (1/2/3 cycles), scrubbing invalid/illegal decodes to bubbles.
// No stalls: only FlushE can suppress an E capture; also counts retirements and flags illegal opcodes.
module ctrl_pipe
  import riscv_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int ALUCTRL_W = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  ctrl_pipe_if.slave  bus
);

  ctrl_t            d_ctrl;
  ctrl_t            e_q;
  ctrl_t            m_q;
  ctrl_t            w_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             illegal_set;
  logic             unused_w_bits;

  // The decoder's controls are only sampled for a real, legal instruction so X never enters E.
  always_comb begin
    d_ctrl = CTRL_BUBBLE;
    if (bus.ValidD && !bus.IllegalD) begin
      d_ctrl.RegWrite   = bus.RegWriteD;
      d_ctrl.ResultSrc  = bus.ResultSrcD;
      d_ctrl.MemWrite   = bus.MemWriteD;
      d_ctrl.Jump       = bus.JumpD;
      d_ctrl.Branch     = bus.BranchD;
      d_ctrl.ALUSrcA    = bus.ALUSrcAD;
      d_ctrl.ALUSrcB    = bus.ALUSrcBD;
      d_ctrl.ALUControl = ALU_CTRL_BITS'(bus.ALUControlD);
      d_ctrl.valid      = 1'b1;
    end
  end

  ctrl_stage_reg u_e (.clk(clk), .rst_n(reset_n), .flush(bus.FlushE), .d(d_ctrl), .q(e_q));
  ctrl_stage_reg u_m (.clk(clk), .rst_n(reset_n), .flush(1'b0),       .d(e_q),    .q(m_q));
  ctrl_stage_reg u_w (.clk(clk), .rst_n(reset_n), .flush(1'b0),       .d(m_q),    .q(w_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (w_q.valid) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Set beats clear; a flushed (wrong-path) illegal decode is ignored.
  assign illegal_set = bus.ValidD & bus.IllegalD & ~bus.FlushE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end else if (bus.illegal_clr) begin
      illegal_q <= 1'b0;
    end
  end

  assign bus.ALUSrcAE     = e_q.ALUSrcA;
  assign bus.ALUSrcBE     = e_q.ALUSrcB;
  assign bus.ALUControlE  = ALUCTRL_W'(e_q.ALUControl);
  assign bus.ResultSrcE0  = e_q.ResultSrc[0];
  assign bus.RegWriteE    = e_q.RegWrite;
  assign bus.PCSrcE       = e_q.valid & ((e_q.Branch & bus.ZeroE) | e_q.Jump);
  assign bus.RegWriteM    = m_q.RegWrite;
  assign bus.MemWriteM    = m_q.MemWrite;
  assign bus.ResultSrcM   = m_q.ResultSrc;
  assign bus.RegWriteW    = w_q.RegWrite;
  assign bus.ResultSrcW   = w_q.ResultSrc;
  assign bus.retired      = retired_q;
  assign bus.illegal_seen = illegal_q;

  assign unused_w_bits = &{1'b0, w_q.MemWrite, w_q.Jump, w_q.Branch,
                           w_q.ALUSrcA, w_q.ALUSrcB, w_q.ALUControl};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe with a 3-deep expected-bundle queue (E/M/W) as scoreboard.
module tb_ctrl_pipe;
  import riscv_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.CNT_W(CW), .ALUCTRL_W(3)) bus ();
  ctrl_pipe #(.CNT_W(CW), .ALUCTRL_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  ctrl_t          pipe_q[$];
  logic [CW-1:0]  exp_ret;
  logic           exp_ill;
  logic           cur_zero;
  ctrl_t          xc;

  localparam ctrl_t LW  = '{RegWrite:1'b1, ResultSrc:RES_MEM, MemWrite:1'b0, Jump:1'b0, Branch:1'b0,
                            ALUSrcA:1'b0, ALUSrcB:1'b1, ALUControl:3'b000, valid:1'b1};
  localparam ctrl_t SW  = '{RegWrite:1'b0, ResultSrc:RES_ALU, MemWrite:1'b1, Jump:1'b0, Branch:1'b0,
                            ALUSrcA:1'b0, ALUSrcB:1'b1, ALUControl:3'b000, valid:1'b1};
  localparam ctrl_t RT  = '{RegWrite:1'b1, ResultSrc:RES_ALU, MemWrite:1'b0, Jump:1'b0, Branch:1'b0,
                            ALUSrcA:1'b1, ALUSrcB:1'b0, ALUControl:3'b010, valid:1'b1};
  localparam ctrl_t BEQ = '{RegWrite:1'b0, ResultSrc:RES_ALU, MemWrite:1'b0, Jump:1'b0, Branch:1'b1,
                            ALUSrcA:1'b0, ALUSrcB:1'b0, ALUControl:3'b001, valid:1'b1};
  localparam ctrl_t JAL = '{RegWrite:1'b1, ResultSrc:RES_PC4, MemWrite:1'b0, Jump:1'b1, Branch:1'b0,
                            ALUSrcA:1'b0, ALUSrcB:1'b0, ALUControl:3'b000, valid:1'b1};
  localparam ctrl_t NOP = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] all_outs();
    return {bus.ALUSrcAE, bus.ALUSrcBE, bus.ALUControlE, bus.ResultSrcE0, bus.RegWriteE,
            bus.PCSrcE, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM,
            bus.RegWriteW, bus.ResultSrcW, bus.retired, bus.illegal_seen};
  endfunction

  task automatic model_reset();
    pipe_q = {NOP, NOP, NOP};
    exp_ret = '0;
    exp_ill = 1'b0;
  endtask

  task automatic check_outputs();
    ctrl_t e, m, w;
    w = pipe_q[0];
    m = pipe_q[1];
    e = pipe_q[2];
    chk("stage_E", {bus.ALUSrcAE, bus.ALUSrcBE, bus.ALUControlE, bus.ResultSrcE0, bus.RegWriteE},
        {e.ALUSrcA, e.ALUSrcB, e.ALUControl, e.ResultSrc[0], e.RegWrite});
    chk("pcsrc_E", bus.PCSrcE, e.valid & ((e.Branch & cur_zero) | e.Jump));
    chk("stage_M", {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM}, {m.RegWrite, m.MemWrite, m.ResultSrc});
    chk("stage_W", {bus.RegWriteW, bus.ResultSrcW}, {w.RegWrite, w.ResultSrc});
    chk("retired", bus.retired, exp_ret);
    chk("illegal_seen", bus.illegal_seen, exp_ill);
  endtask

  // Drive one Decode slot, clock it, update the scoreboard, then check E/M/W.
  task automatic step(input logic valid, input logic ill, input ctrl_t c,
                      input logic flush, input logic clr, input logic zero);
    ctrl_t cap, gone;
    bus.ValidD      = valid;
    bus.IllegalD    = ill;
    bus.RegWriteD   = c.RegWrite;
    bus.ResultSrcD  = c.ResultSrc;
    bus.MemWriteD   = c.MemWrite;
    bus.JumpD       = c.Jump;
    bus.BranchD     = c.Branch;
    bus.ALUSrcAD    = c.ALUSrcA;
    bus.ALUSrcBD    = c.ALUSrcB;
    bus.ALUControlD = c.ALUControl;
    bus.FlushE      = flush;
    bus.illegal_clr = clr;
    @(posedge clk);
    cap = NOP;
    if (!flush && valid && !ill) begin
      cap = c;
      cap.valid = 1'b1;
    end
    gone = pipe_q.pop_front();
    if (gone.valid) exp_ret = exp_ret + 1'b1;
    pipe_q.push_back(cap);
    if (valid && ill && !flush) exp_ill = 1'b1;
    else if (clr) exp_ill = 1'b0;
    #1;
    bus.ZeroE = zero;
    cur_zero  = zero;
    #1;
    check_outputs();
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_mid();
    #1 reset_n = 1'b0;
    #1 chk("rst_async_outs", all_outs(), 20'h0);
    model_reset();
    cur_zero = 1'b0;
    bus.ZeroE = 1'b0;
    @(posedge clk);
    #2 chk("rst_held_outs", all_outs(), 20'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    xc = 'x;
    cur_zero = 1'b0;
    bus.ZeroE = 1'b0;
    bus.ValidD = 1'b0; bus.IllegalD = 1'b0; bus.RegWriteD = 1'b0; bus.ResultSrcD = 2'b00;
    bus.MemWriteD = 1'b0; bus.JumpD = 1'b0; bus.BranchD = 1'b0; bus.ALUSrcAD = 1'b0;
    bus.ALUSrcBD = 1'b0; bus.ALUControlD = 3'b000; bus.FlushE = 1'b0; bus.illegal_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_outputs();
    chk("reset_all_zero", all_outs(), 20'h0);
    reset_n = 1'b1;

    // Back-to-back stream; beq not taken, jal taken.
    step(1'b1, 1'b0, LW,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, SW,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, RT,  1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, BEQ, 1'b0, 1'b0, 1'b0);
    chk("beq_not_taken", bus.PCSrcE, 1'b0);
    step(1'b1, 1'b0, JAL, 1'b0, 1'b0, 1'b0);
    chk("jal_taken", bus.PCSrcE, 1'b1);
    bubble(4);
    chk("stream_retired", bus.retired, 4'd5);

    // Taken branch, then the same branch flushed.
    step(1'b1, 1'b0, BEQ, 1'b0, 1'b0, 1'b1);
    chk("beq_taken", bus.PCSrcE, 1'b1);
    step(1'b1, 1'b0, BEQ, 1'b1, 1'b0, 1'b1);
    chk("beq_flushed", bus.PCSrcE, 1'b0);
    bubble(4);
    chk("flush_not_retired", bus.retired, 4'd6);

    // Illegal handling with X on every D control.
    step(1'b1, 1'b1, xc, 1'b1, 1'b0, 1'b0);
    chk("ill_flushed_path", bus.illegal_seen, 1'b0);
    step(1'b1, 1'b1, xc, 1'b0, 1'b0, 1'b0);
    chk("ill_set", bus.illegal_seen, 1'b1);
    chk("ill_no_x", $isunknown(all_outs()), 1'b0);
    step(1'b1, 1'b1, xc, 1'b0, 1'b1, 1'b0);
    chk("ill_set_beats_clr", bus.illegal_seen, 1'b1);
    chk("ill_no_x2", $isunknown(all_outs()), 1'b0);
    step(1'b0, 1'b0, NOP, 1'b0, 1'b1, 1'b0);
    chk("ill_cleared", bus.illegal_seen, 1'b0);
    bubble(3);

    // Reset with E/M/W all occupied, then a lw reaches W three edges after capture.
    step(1'b1, 1'b0, LW, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, RT, 1'b0, 1'b0, 1'b0);
    reset_mid();
    step(1'b1, 1'b0, LW, 1'b0, 1'b0, 1'b0);
    chk("lw_not_yet_W", {bus.RegWriteW, bus.ResultSrcW}, 3'b000);
    bubble(1);
    chk("lw_not_yet_W2", {bus.RegWriteW, bus.ResultSrcW}, 3'b000);
    bubble(1);
    chk("lw_at_W", {bus.RegWriteW, bus.ResultSrcW}, 3'b101);
    bubble(1);
    chk("lw_retired", bus.retired, 4'd1);

    // Counter wrap: 17 retirements on a 4-bit counter.
    reset_mid();
    for (int i = 0; i < 17; i++) begin
      case (i % 3)
        0:       step(1'b1, 1'b0, LW, 1'b0, 1'b0, 1'b0);
        1:       step(1'b1, 1'b0, RT, 1'b0, 1'b0, 1'b0);
        default: step(1'b1, 1'b0, SW, 1'b0, 1'b0, 1'b0);
      endcase
    end
    bubble(4);
    chk("retired_wrap", bus.retired, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
